// File: rtl/gs_audio_pkg.sv
// Shared widths, types and small helpers for the General Sound audio output path.
package gs_audio_pkg;

    localparam int unsigned GS_SMP_W       = 15;
    localparam int unsigned I2S_WORD_W     = 16;
    localparam int unsigned I2S_SLOT_W     = 32;
    localparam int unsigned I2S_FRAME_BITS = 64;
    localparam int unsigned I2S_BITCNT_W   = $clog2(I2S_FRAME_BITS);

    typedef logic signed [GS_SMP_W-1:0] gs_sample_t;
    typedef logic [I2S_WORD_W-1:0]      i2s_word_t;
    typedef logic [I2S_BITCNT_W-1:0]    i2s_bitcnt_t;

    // Word-select polarity as it appears on LRCK.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_t;

    // 15-bit signed sample to 16-bit DAC word: plain x2, LSB zero.
    function automatic i2s_word_t gs_to_i2s_word(input gs_sample_t s);
        return {s, 1'b0};
    endfunction

    // Bit at position idx of the 64-bit frame: two 32-bit slots, each a 16-bit
    // word MSB first followed by 16 zero bits.
    function automatic logic i2s_slot_bit(input i2s_word_t   wl,
                                          input i2s_word_t   wr,
                                          input i2s_bitcnt_t idx);
        i2s_word_t   w;
        logic [4:0]  pos;
        logic        b;
        w   = idx[I2S_BITCNT_W-1] ? wr : wl;
        pos = idx[4:0];
        b   = 1'b0;
        if (!pos[4]) begin
            b = w[~pos[3:0]];
        end
        return b;
    endfunction

endpackage

// File: rtl/gs_boxcar_dec.sv
// Power-of-two boxcar decimator: sums 2^DEC_LOG2 CE-qualified samples and
// holds the floored average until the next window completes.
module gs_boxcar_dec #(
    parameter int unsigned W        = 15,
    parameter int unsigned DEC_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] hold
);

    if (DEC_LOG2 == 0) begin : g_pass

        logic signed [W-1:0] hold_q, hold_d;

        // Pass-through: every CE sample goes straight into the hold register.
        always_comb begin
            hold_d = hold_q;
            if (ce) begin
                hold_d = din;
            end
        end

        // Hold register.
        always_ff @(posedge clk) begin
            if (reset) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_d;
            end
        end

        assign hold = hold_q;

    end else begin : g_avg

        localparam int unsigned AW = W + DEC_LOG2;

        logic signed [AW-1:0]     acc_q, acc_d;
        logic signed [AW-1:0]     din_x;
        logic signed [AW-1:0]     sum;
        logic signed [AW-1:0]     avg;
        logic [DEC_LOG2-1:0]      win_q, win_d;
        logic signed [W-1:0]      hold_q, hold_d;

        // Accumulate; on the last CE of a window publish the floored mean and
        // restart from zero. The sum of 2^DEC_LOG2 W-bit values always fits AW bits.
        always_comb begin
            din_x  = {{DEC_LOG2{din[W-1]}}, din};
            sum    = acc_q + din_x;
            avg    = sum >>> DEC_LOG2;
            acc_d  = acc_q;
            win_d  = win_q;
            hold_d = hold_q;
            if (ce) begin
                win_d = win_q + 1'b1;
                if (win_q == '1) begin
                    hold_d = avg[W-1:0];
                    acc_d  = '0;
                end else begin
                    acc_d  = sum;
                end
            end
        end

        // Accumulator, window counter and hold registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                acc_q  <= '0;
                win_q  <= '0;
                hold_q <= '0;
            end else begin
                acc_q  <= acc_d;
                win_q  <= win_d;
                hold_q <= hold_d;
            end
        end

        assign hold = hold_q;

    end

endmodule

// File: rtl/gs_i2s_out.sv
// General Sound output stage: per-channel boxcar decimation followed by a
// Philips I2S serializer (64 BCK per frame, 16-bit words in 32-bit slots).
module gs_i2s_out
    import gs_audio_pkg::*;
#(
    parameter int unsigned BCLK_HALF = 7,
    parameter int unsigned DEC_LOG2  = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       CE,
    input  logic signed [GS_SMP_W-1:0] IN_L,
    input  logic signed [GS_SMP_W-1:0] IN_R,
    input  logic                       MUTE,
    output logic                       I2S_BCK,
    output logic                       I2S_LRCK,
    output logic                       I2S_DATA,
    output logic                       FRAME_STB
);

    localparam int unsigned PRESC_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BCLK_HALF - 1);

    gs_sample_t hold_l;
    gs_sample_t hold_r;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               bck_q, bck_d;
    i2s_bitcnt_t        bitcnt_q, bitcnt_d;
    i2s_ch_t            lrck_q, lrck_d;
    logic               data_q, data_d;
    logic               stb_q, stb_d;
    i2s_word_t          word_l_q, word_l_d;
    i2s_word_t          word_r_q, word_r_d;

    logic               wrap;
    logic               fall;
    logic               latch;

    gs_boxcar_dec #(
        .W        (GS_SMP_W),
        .DEC_LOG2 (DEC_LOG2)
    ) u_dec_l (
        .clk   (CLK),
        .reset (RESET),
        .ce    (CE),
        .din   (IN_L),
        .hold  (hold_l)
    );

    gs_boxcar_dec #(
        .W        (GS_SMP_W),
        .DEC_LOG2 (DEC_LOG2)
    ) u_dec_r (
        .clk   (CLK),
        .reset (RESET),
        .ce    (CE),
        .din   (IN_R),
        .hold  (hold_r)
    );

    // Prescaler, BCK, bit counter, frame latch and slot mux; everything
    // visible on the I2S pins moves only on a BCK fall.
    always_comb begin
        wrap  = (presc_q == PRESC_LAST);
        fall  = wrap && bck_q;
        latch = fall && (bitcnt_q == '1);

        presc_d  = wrap ? '0 : presc_q + 1'b1;
        bck_d    = wrap ? ~bck_q : bck_q;
        bitcnt_d = bitcnt_q;
        lrck_d   = lrck_q;
        data_d   = data_q;
        stb_d    = latch;
        word_l_d = word_l_q;
        word_r_d = word_r_q;

        if (latch) begin
            word_l_d = MUTE ? '0 : gs_to_i2s_word(hold_l);
            word_r_d = MUTE ? '0 : gs_to_i2s_word(hold_r);
        end

        if (fall) begin
            bitcnt_d = bitcnt_q + 1'b1;
            lrck_d   = i2s_ch_t'(bitcnt_d[I2S_BITCNT_W-1]);
            // Indexing with the pre-increment count yields the one-BCK I2S
            // delay; at the 63->0 wrap this is slot bit 63 (always zero), so
            // the freshly latched words are not needed in the same cycle.
            data_d   = i2s_slot_bit(word_l_q, word_r_q, bitcnt_q);
        end
    end

    // State registers; synchronous reset restarts the stream at bit 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q  <= '0;
            bck_q    <= 1'b0;
            bitcnt_q <= '0;
            lrck_q   <= CH_LEFT;
            data_q   <= 1'b0;
            stb_q    <= 1'b0;
            word_l_q <= '0;
            word_r_q <= '0;
        end else begin
            presc_q  <= presc_d;
            bck_q    <= bck_d;
            bitcnt_q <= bitcnt_d;
            lrck_q   <= lrck_d;
            data_q   <= data_d;
            stb_q    <= stb_d;
            word_l_q <= word_l_d;
            word_r_q <= word_r_d;
        end
    end

    assign I2S_BCK   = bck_q;
    assign I2S_LRCK  = lrck_q;
    assign I2S_DATA  = data_q;
    assign FRAME_STB = stb_q;

endmodule

// File: tb/tb_gs_i2s_out.sv
// Bench for gs_i2s_out: an arithmetic reference model (time index -> expected
// pins, queue-free integer averaging) plus an I2S receiver that decodes words.
module tb_gs_i2s_out;

    localparam int unsigned H         = 7;
    localparam int unsigned DEC       = 2;
    localparam int          NWIN      = 1 << DEC;
    localparam int unsigned FRAME_CLK = 128 * H;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              ce   = 1'b0;
    logic              mute = 1'b0;
    logic signed [14:0] in_l = '0;
    logic signed [14:0] in_r = '0;
    logic              bck, lrck, data, stb;

    int n_checks = 0;
    int n_errors = 0;

    gs_i2s_out #(
        .BCLK_HALF (H),
        .DEC_LOG2  (DEC)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .CE        (ce),
        .IN_L      (in_l),
        .IN_R      (in_r),
        .MUTE      (mute),
        .I2S_BCK   (bck),
        .I2S_LRCK  (lrck),
        .I2S_DATA  (data),
        .FRAME_STB (stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // ---------------- reference model (updated on each rising edge) -------------
    int unsigned k = 0;
    int          acc_l = 0, acc_r = 0, win = 0, hold_l = 0, hold_r = 0, mfr = 0;
    logic [15:0] wl = '0, wr = '0;

    always @(posedge clk) begin
        if (rst) begin
            k = 0; acc_l = 0; acc_r = 0; win = 0; hold_l = 0; hold_r = 0;
            wl = '0; wr = '0; mfr = 0;
        end else begin
            k++;
            if (k % FRAME_CLK == 0) begin
                wl = mute ? 16'h0 : 16'(hold_l * 2);
                wr = mute ? 16'h0 : 16'(hold_r * 2);
                mfr++;
            end
            if (ce) begin
                acc_l += int'(in_l);
                acc_r += int'(in_r);
                win++;
                if (win == NWIN) begin
                    hold_l = fdiv(acc_l, NWIN);
                    hold_r = fdiv(acc_r, NWIN);
                    acc_l = 0; acc_r = 0; win = 0;
                end
            end
        end
    end

    // ---------------- pin check and I2S receiver (falling edge) -----------------
    logic [15:0] dec_l [64];
    logic [15:0] dec_r [64];
    logic        dok_l [64];
    logic        dok_r [64];
    int          dfr = 0, slot_pos = -1, cyc = 0;
    int          last_rise_cyc = 0, lrck_fall_cyc = 0, bck_per = 0, lrck_per = 0;
    logic        fall_seen = 1'b0, last_rise_lrck = 1'b0;
    logic        prev_bck = 1'b0, prev_lrck = 1'b0, prev_data = 1'b0;
    logic [15:0] sh = '0;

    always @(negedge clk) begin
        int unsigned b, idx, pos;
        logic [15:0] w;
        logic        bck_e, lrck_e, data_e, stb_e;
        cyc++;
        b      = (k / (2 * H)) % 64;
        bck_e  = ((k / H) % 2) == 1;
        lrck_e = (b >= 32);
        stb_e  = (k != 0) && (k % FRAME_CLK == 0);
        data_e = 1'b0;
        if (b != 0) begin
            idx = b - 1;
            w   = (idx >= 32) ? wr : wl;
            pos = idx % 32;
            if (pos < 16) data_e = w[15 - pos];
        end
        chk("pins", 32'({bck, lrck, data, stb}), 32'({bck_e, lrck_e, data_e, stb_e}));

        if (k == 0) begin
            dfr = 0; slot_pos = -1; last_rise_cyc = 0; lrck_fall_cyc = 0;
            fall_seen = 1'b0; last_rise_lrck = 1'b0; sh = '0;
            for (int i = 0; i < 64; i++) begin
                dok_l[i] = 1'b0; dok_r[i] = 1'b0;
            end
        end else begin
            if ((lrck != prev_lrck) || (data != prev_data))
                chk("chg_on_fall", 32'({prev_bck, bck}), 32'(2'b10));
            if (prev_lrck && !lrck) begin
                if (fall_seen) lrck_per = cyc - lrck_fall_cyc;
                lrck_fall_cyc = cyc;
                fall_seen = 1'b1;
            end
            if (!prev_bck && bck) begin
                if (last_rise_cyc != 0) bck_per = cyc - last_rise_cyc;
                last_rise_cyc = cyc;
                if (lrck != last_rise_lrck) begin
                    if (!lrck && dfr < 63) dfr++;
                    slot_pos = 0;
                    last_rise_lrck = lrck;
                end else begin
                    slot_pos++;
                end
                if (slot_pos >= 1 && slot_pos <= 16) sh = {sh[14:0], data};
                if (slot_pos == 1 && !lrck && fall_seen)
                    chk("msb_dly", 32'(cyc - lrck_fall_cyc), 32'(3 * H));
                if (slot_pos == 16) begin
                    if (!lrck) begin dec_l[dfr] = sh; dok_l[dfr] = 1'b1; end
                    else       begin dec_r[dfr] = sh; dok_r[dfr] = 1'b1; end
                end
            end
        end
        prev_bck = bck; prev_lrck = lrck; prev_data = data;
    end

    // ---------------- stimulus ---------------------------------------------------
    int   ce_mode = 3;   // 0 off, 1 every 4th CLK, 2 random, 3 every CLK, 4 manual
    int   phase   = 0;
    logic rand_in = 1'b0;

    task automatic tick();
        @(posedge clk);
        #2;
        phase++;
        case (ce_mode)
            0: ce = 1'b0;
            1: ce = (phase % 4 == 0);
            2: ce = 1'($urandom_range(0, 1));
            3: ce = 1'b1;
            default: ;
        endcase
        if (rand_in) begin
            in_l = 15'($urandom);
            in_r = 15'($urandom);
            mute = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic wait_stb(input int n);
        int seen, t;
        seen = 0; t = 0;
        while (seen < n && t < 3 * int'(FRAME_CLK) * n) begin
            tick();
            t++;
            if (stb) seen++;
        end
        if (seen < n) chk("stb_timeout", 32'(seen), 32'(n));
    endtask

    // Checks the decoded words of the frame currently on the wire.
    task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
        int f;
        f = (mfr > 63) ? 63 : mfr;
        wait_stb(1);
        chk({tag, "_L"}, 32'({dok_l[f], dec_l[f]}), 32'({1'b1, el}));
        chk({tag, "_R"}, 32'({dok_r[f], dec_r[f]}), 32'({1'b1, er}));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_pins", 32'({bck, lrck, data, stb}), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int first;
        // 1: reset release with a constant input, CE every cycle
        in_l = 15'sh1000; in_r = 15'sh1000; ce_mode = 3;
        tick(); tick();
        do_reset();
        check_frame("t1_f0", 16'h0000, 16'h0000);
        check_frame("t1_f1", 16'h2000, 16'h2000);

        // 2: CE every 4th CLK, opposite-sign inputs
        ce_mode = 1; in_l = 15'sd4096; in_r = -15'sd4096;
        wait_stb(2);
        check_frame("t2", 16'h2000, 16'hE000);

        // 5: MUTE across exactly one frame latch
        ce_mode = 3; in_l = 15'sd100; in_r = -15'sd7;
        wait_stb(1);
        mute = 1'b1;
        wait_stb(1);
        mute = 1'b0;
        check_frame("t5_mute", 16'h0000, 16'h0000);
        check_frame("t5_resume", 16'd200, 16'hFFF2);

        // random inputs, CE and MUTE against the model
        ce_mode = 2; rand_in = 1'b1;
        wait_stb(5);
        rand_in = 1'b0; mute = 1'b0;

        // 4: measured periods
        chk("bck_per", 32'(bck_per), 32'(2 * H));
        chk("lrck_per", 32'(lrck_per), 32'(FRAME_CLK));

        // 3: one window with mixed values, then CE idle
        ce_mode = 4; ce = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin in_l = 15'sd1; in_r = -15'sd1; end
                1: begin in_l = 15'sd2; in_r = -15'sd1; end
                2: begin in_l = 15'sd3; in_r = -15'sd1; end
                default: begin in_l = 15'sd6; in_r = -15'sd2; end
            endcase
            ce = 1'b1;
            tick();
        end
        ce = 1'b0; in_l = 15'sd500; in_r = 15'sd500;
        check_frame("t3_f0", 16'h0000, 16'h0000);
        check_frame("t3_f1", 16'h0006, 16'hFFFC);

        // 6: reset in the middle of a frame
        ce_mode = 3;
        for (int t = 0; t < 2 * int'(FRAME_CLK); t++) begin
            if (((k / (2 * H)) % 64) == 40) break;
            tick();
        end
        chk("at_bit40", 32'((k / (2 * H)) % 64), 32'd40);
        rst = 1'b1;
        tick();
        chk("rst_mid", 32'({bck, lrck, data, stb}), 32'd0);
        rst = 1'b0;
        first = 0;
        for (int n = 1; n <= 4 * int'(H); n++) begin
            tick();
            if (bck) begin first = n; break; end
        end
        chk("bck_first", 32'(first), 32'(H));
        check_frame("t6_f0", 16'h0000, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
